// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths and enums for the RAM_RW block and its sequential master
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 4;
    localparam int RAM_DATA_WIDTH = 4;

    typedef enum logic {
        OP_FILL   = 1'b0,
        OP_VERIFY = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ram_rw.sv
// rtl/ram_rw.sv - single-port RAM with synchronous write and registered read
module ram_rw
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write on wr_en; read data is the pre-write word, valid the cycle after the address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_seq_master.sv
// rtl/ram_seq_master.sv - sequential FILL/VERIFY initiator over a wrapping RAM address range
module ram_seq_master
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             op,
    input  logic [ADDR_WIDTH-1:0]            base,
    input  logic [ADDR_WIDTH:0]              len,
    input  logic [DATA_WIDTH-1:0]            seed,
    output logic                             wr_en,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH:0]              err_count,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] sum
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state;
    logic [ADDR_WIDTH:0]   rem;       // words still to issue, including the current one
    logic [DATA_WIDTH-1:0] pat;       // pattern value for the address currently on addr
    logic [DATA_WIDTH-1:0] exp_data;  // pattern value for the read now returning on rdata
    logic                  rd_valid;  // rdata holds a word issued last cycle
    logic [ADDR_WIDTH:0]   len_c;

    assign len_c = (len > MAX_LEN) ? MAX_LEN : len;

    // Command FSM with registered RAM-side outputs and the read-compare pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_en     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            sum       <= '0;
            rem       <= '0;
            pat       <= '0;
            exp_data  <= '0;
            rd_valid  <= 1'b0;
        end else begin
            // The compare lags the read address by one cycle, so it runs in READ and DRAIN
            if (rd_valid) begin
                if (rdata != exp_data) begin
                    err_count <= err_count + LW'(1);
                end
                sum <= sum + {{ADDR_WIDTH{1'b0}}, rdata};
            end

            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    rd_valid <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        err_count <= '0;
                        sum       <= '0;
                        addr      <= base;
                        pat       <= seed;
                        rem       <= len_c;
                        if (len_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (op_e'(op) == OP_VERIFY) begin
                            state <= READ;
                            wr_en <= 1'b0;
                            wdata <= '0;
                        end else begin
                            state <= FILL;
                            wr_en <= 1'b1;
                            wdata <= seed;
                        end
                    end
                end
                FILL: begin
                    if (rem == LW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        wr_en <= 1'b0;
                        wdata <= '0;
                    end else begin
                        addr  <= addr + 1'b1;
                        wdata <= wdata + 1'b1;
                        rem   <= rem - LW'(1);
                    end
                end
                READ: begin
                    rd_valid <= 1'b1;
                    exp_data <= pat;
                    pat      <= pat + 1'b1;
                    if (rem == LW'(1)) begin
                        state <= DRAIN;
                    end else begin
                        addr <= addr + 1'b1;
                        rem  <= rem - LW'(1);
                    end
                end
                DRAIN: begin
                    rd_valid <= 1'b0;
                    state    <= DONE;
                    done     <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_seq_master.sv
// tb/tb_ram_seq_master.sv - directed bench for ram_seq_master driving ram_rw
module tb_ram_seq_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [3:0] base;
    logic [4:0] len;
    logic [3:0] seed;
    logic       wr_en;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic       busy;
    logic       done;
    logic [4:0] err_count;
    logic [7:0] sum;

    logic       bd_sel = 1'b0;
    logic       bd_we = 1'b0;
    logic [3:0] bd_addr = '0;
    logic [3:0] bd_wdata = '0;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [3:0] ram_wdata;

    int tests = 0;
    int fails = 0;

    logic [3:0] model_mem [16];

    always #5 clk = ~clk;

    assign ram_we    = bd_sel ? bd_we    : wr_en;
    assign ram_addr  = bd_sel ? bd_addr  : addr;
    assign ram_wdata = bd_sel ? bd_wdata : wdata;

    ram_seq_master u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base(base), .len(len),
        .seed(seed), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .err_count(err_count), .sum(sum)
    );

    ram_rw u_ram (
        .clk(clk), .wr_en(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(rdata)
    );

    typedef struct {
        logic       o;
        logic [3:0] b;
        logic [4:0] l;
        logic [3:0] s;
        int         lat;
        int         err;
        int         sm;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (u_ram.mem[i] !== model_mem[i]) begin
                bad++;
            end
        end
        check(name, bad, 0);
    endtask

    // One operation: checks per-cycle RAM outputs, done latency, pulse width and result hold
    task automatic run(input string name, input logic o, input logic [3:0] b,
                       input logic [4:0] l, input logic [3:0] s, input int exp_lat,
                       input int exp_err, input int exp_sum, input int inject);
        int         lc;
        int         lat = -1;
        int         bad = 0;
        logic [3:0] ea;
        logic [3:0] ed;
        lc = (l > 5'd16) ? 16 : int'(l);
        @(negedge clk);
        start = 1'b1; op = o; base = b; len = l; seed = s;
        @(posedge clk);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0 || k == inject + 1) start = 1'b0;
            if (k == inject) begin
                start = 1'b1; op = 1'b1; base = 4'd8; len = 5'd3; seed = 4'd9;
            end
            ea = b + 4'(k);
            ed = s + 4'(k);
            if (!busy) bad++;
            if (done) begin
                if (wr_en) bad++;
                lat = k;
                break;
            end
            if (k < lc) begin
                if (wr_en !== !o || addr !== ea || wdata !== (o ? 4'd0 : ed)) bad++;
                if (!o) model_mem[ea] = ed;
            end else if (wr_en) begin
                bad++;
            end
        end
        start = 1'b0;
        check({name, " latency"}, lat, exp_lat);
        check({name, " cycle outputs"}, bad, 0);
        @(negedge clk);
        check({name, " post-done busy/done"}, {30'd0, busy, done}, 0);
        if (o || lc == 0) begin
            check({name, " err_count"}, int'(err_count), exp_err);
            check({name, " sum"}, int'(sum), exp_sum);
        end
        if (!o) check_mem({name, " mem"});
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 4'd0,  5'd16, 4'd3, 16, 0, 0};
        vecs[1] = '{1'b1, 4'd0,  5'd16, 4'd3, 17, 0, 120};
        vecs[2] = '{1'b0, 4'd14, 5'd4,  4'd0, 4,  0, 0};
        vecs[3] = '{1'b1, 4'd14, 5'd4,  4'd1, 5,  4, 6};
        vecs[4] = '{1'b1, 4'd3,  5'd0,  4'd1, 0,  0, 0};
        vecs[5] = '{1'b0, 4'd0,  5'd20, 4'd7, 16, 0, 0};
        vecs[6] = '{1'b1, 4'd0,  5'd16, 4'd7, 17, 0, 120};

        for (int i = 0; i < 16; i++) model_mem[i] = 4'd0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; base = '0; len = '0; seed = '0;
        #1;
        check("reset outputs", int'({wr_en, addr, wdata, busy, done, err_count, sum}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run($sformatf("vec%0d", i), vecs[i].o, vecs[i].b, vecs[i].l, vecs[i].s,
                vecs[i].lat, vecs[i].err, vecs[i].sm, -10);
        end

        // Corrupt word 5 (holds 12) to 0 behind the master's back
        @(negedge clk);
        bd_sel = 1'b1; bd_we = 1'b1; bd_addr = 4'd5; bd_wdata = 4'd0;
        @(negedge clk);
        bd_sel = 1'b0; bd_we = 1'b0;
        run("corrupt verify", 1'b1, 4'd0, 5'd16, 4'd7, 17, 1, 108, -10);

        // A start pulse in cycle 3 of a FILL must not disturb it
        run("mid-fill start", 1'b0, 4'd0, 5'd16, 4'd0, 16, 0, 0, 3);

        // Reset during cycle 7 of a 16-word FILL
        @(negedge clk);
        start = 1'b1; op = 1'b0; base = 4'd0; len = 5'd16; seed = 4'd5;
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            model_mem[k] = 4'd5 + 4'(k);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-op reset outputs", int'({wr_en, addr, wdata, busy, done, err_count, sum}), 0);
        @(negedge clk);
        check_mem("mid-op reset mem");
        rst_n = 1'b1;
        run("fill after reset", 1'b0, 4'd0, 5'd16, 4'd2, 16, 0, 0, -10);
        run("verify after reset", 1'b1, 4'd0, 5'd16, 4'd2, 17, 0, 120, -10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
